// File: rtl/coef_bank_sync.sv
// coef_bank_sync: writable IIR coefficient bank. The coefficient set the
// filter sees is swapped only on a sample boundary, so a sample is never
// computed with a mixture of old and new coefficients.

// One coefficient set: NumCoefs registers with a decoded write strobe.
module coef_bank_sync_set #(
    parameter int Width    = 22,
    parameter int NumCoefs = 5,
    parameter int IdxW     = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [IdxW-1:0]                    idx,
    input  logic [Width-1:0]                   data,
    output logic [NumCoefs-1:0][Width-1:0]     row
);

    // Coefficient storage; the index is range-checked by the parent before we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
        end else if (we) begin
            for (int k = 0; k < NumCoefs; k++) begin
                if (idx == IdxW'(k)) row[k] <= data;
            end
        end
    end

endmodule

module coef_bank_sync #(
    parameter int Width    = 22,
    parameter int NumCoefs = 5,
    parameter int NumSets  = 4,
    parameter int SelW     = (NumSets  > 1) ? $clog2(NumSets)  : 1,
    parameter int IdxW     = (NumCoefs > 1) ? $clog2(NumCoefs) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_tick,
    input  logic [SelW-1:0]              sel,
    input  logic                         wr_en,
    input  logic [SelW-1:0]              wr_set,
    input  logic [IdxW-1:0]              wr_idx,
    input  logic [Width-1:0]             wr_data,
    output logic [NumCoefs*Width-1:0]    coef_flat,
    output logic [SelW-1:0]              active_set,
    output logic                         coef_update,
    output logic                         pending,
    output logic                         wr_err
);

    localparam logic [IdxW:0] IdxLim = (IdxW+1)'(NumCoefs);
    localparam logic [SelW:0] SetLim = (SelW+1)'(NumSets);

    typedef enum logic {STABLE = 1'b0, ARMED = 1'b1} state_t;

    state_t state, state_nxt;

    logic [NumSets-1:0][NumCoefs-1:0][Width-1:0] bank;
    logic [NumSets-1:0]                          set_we;
    logic [SelW-1:0]                             sel_eff;
    logic                                        wr_ok;
    logic                                        wr_active;
    logic                                        wr_loaded;
    logic                                        load;
    logic                                        dirty;

    // Out-of-range selects fall back to set 0 (only possible when NumSets is not a power of 2).
    assign sel_eff   = ({1'b0, sel} < SetLim) ? sel : '0;
    assign wr_ok     = wr_en && ({1'b0, wr_idx} < IdxLim) && ({1'b0, wr_set} < SetLim);
    // Write hitting the set currently on coef_flat: output is now stale.
    assign wr_active = wr_ok && (wr_set == active_set);
    // Write hitting the set being loaded this edge: the load captures the pre-write value.
    assign wr_loaded = wr_ok && (wr_set == sel_eff);
    assign load      = (state == ARMED) && sample_tick;

    genvar s;
    generate
        for (s = 0; s < NumSets; s++) begin : g_set
            assign set_we[s] = wr_ok && (wr_set == SelW'(s));
            coef_bank_sync_set #(
                .Width    (Width),
                .NumCoefs (NumCoefs),
                .IdxW     (IdxW)
            ) u_set (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (set_we[s]),
                .idx   (wr_idx),
                .data  (wr_data),
                .row   (bank[s])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STABLE;
        else        state <= state_nxt;
    end

    // Next state: arm on a set change or active-set rewrite; disarm on load or when the request is withdrawn.
    always_comb begin
        state_nxt = state;
        case (state)
            STABLE: begin
                if ((sel_eff != active_set) || wr_active) state_nxt = ARMED;
            end
            ARMED: begin
                if (sample_tick)
                    state_nxt = wr_loaded ? ARMED : STABLE;
                else if ((sel_eff == active_set) && !dirty && !wr_active)
                    state_nxt = STABLE;
            end
            default: state_nxt = STABLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        pending = (state == ARMED);
    end

    // Remembers that the active set was rewritten since it was last loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         dirty <= 1'b0;
        else if (load)      dirty <= wr_loaded;
        else if (wr_active) dirty <= 1'b1;
    end

    // Output coefficient registers, loaded only on a sample boundary while armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_flat   <= '0;
            active_set  <= '0;
            coef_update <= 1'b0;
        end else begin
            coef_update <= load;
            if (load) begin
                coef_flat  <= bank[sel_eff];
                active_set <= sel_eff;
            end
        end
    end

    // Rejected write strobe, one cycle after the offending wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err <= 1'b0;
        else        wr_err <= wr_en && !wr_ok;
    end

endmodule
